mano_timing_sequencer: RTL and testbench

- Generates the timing signals t0..t7 and the decoded instruction class q1..q3 that the control-logic block consumes.
- Contains a 3-bit sequence counter (SC) and its one-hot decoder, the opcode/IR latch with class decode, and a run/halt state machine.
- Ends each instruction at the class-specific last step: q1 at T3, q2 at T5, q3 at T7.
- Sits between the memory/bus path (opcode in) and the combinational control logic (x1..x8).

---
 rtl/mano_timing_sequencer.sv | 108 ++++++++++
 tb/tb_mano_timing_sequencer.sv | 114 +++++++++++
 2 files changed

// File: rtl/mano_timing_sequencer.sv
// mano_timing_sequencer: sequence counter, T0..T7 decoder, IR class decode and run/halt control
//
// Ports:
//    clk         system clock, all state changes on the rising edge
//    rst_n       synchronous reset, active low
//    run         start/resume request (level), ignored while running
//    halt_req    halt request, latched in RUN until the next instruction boundary
//    opcode_in   opcode field from the bus, captured during T2
//    step        (MANO_SINGLE_STEP_EN only) resume from PAUSE at T0
//    t           one-hot timing, bit i drives ti
//    q           one-hot class, bit0=q1 bit1=q2 bit2=q3 (000 for illegal opcode)
//    instr_done  high during the final timing step of each instruction
//    illegal_op  sticky, set when opcode 2'b11 is captured
//    icount      retired-instruction count (wraps)
//    running     high while in RUN
//
// Optional feature: define MANO_SINGLE_STEP_EN to stop in PAUSE after every
// instruction until a step pulse.
module mano_timing_sequencer #(
   parameter int END_Q1 = 3,
   parameter int END_Q2 = 5,
   parameter int END_Q3 = 7,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             halt_req,
   input  logic [1:0]       opcode_in,
`ifdef MANO_SINGLE_STEP_EN
   input  logic             step,
`endif
   output logic [7:0]       t,
   output logic [2:0]       q,
   output logic             instr_done,
   output logic             illegal_op,
   output logic [CNT_W-1:0] icount,
   output logic             running
);
   typedef enum logic [1:0] {IDLE, RUN, HALTED, PAUSE} state_t;
   localparam logic [2:0] E1 = 3'(END_Q1);
   localparam logic [2:0] E2 = 3'(END_Q2);
   localparam logic [2:0] E3 = 3'(END_Q3);
   state_t     state;
   logic [2:0] sc, sc_n, q_dec, q_n;
   logic       halt_l, go, last_n;
   // SC==7 always ends the instruction so the counter can never run past T7
   function automatic logic is_last(input logic [2:0] s, input logic [2:0] c);
      return s == 3'd7 || (c == 3'b001 && s == E1) || (c == 3'b010 && s == E2) ||
             (c == 3'b100 && s == E3) || (c == 3'b000 && s == 3'd3);
   endfunction
   assign q_dec  = opcode_in == 2'b11 ? 3'b000 : 3'b001 << opcode_in;
   assign sc_n   = sc + 3'd1;
   assign q_n    = sc == 3'd2 ? q_dec : q;
   // instr_done is registered, so the end test is evaluated for the next step
   assign last_n = is_last(sc_n, q_n);
`ifdef MANO_SINGLE_STEP_EN
   assign go = state == PAUSE ? step : run && !halt_req;
`else
   assign go = run && !halt_req;
`endif
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         sc         <= 3'd0;
         t          <= 8'h00;
         q          <= 3'b000;
         instr_done <= 1'b0;
         illegal_op <= 1'b0;
         icount     <= '0;
         running    <= 1'b0;
         halt_l     <= 1'b0;
      end else if (state != RUN) begin
         instr_done <= 1'b0;
         if (go) begin
            state   <= RUN;
            sc      <= 3'd0;
            t       <= 8'h01;
            running <= 1'b1;
         end
      end else if (instr_done) begin
         sc         <= 3'd0;
         icount     <= icount + 1'b1;
         halt_l     <= 1'b0;
         instr_done <= 1'b0;
         if (halt_l || halt_req) begin
            state   <= HALTED;
            t       <= 8'h00;
            running <= 1'b0;
         end else begin
`ifdef MANO_SINGLE_STEP_EN
            state   <= PAUSE;
            t       <= 8'h00;
            running <= 1'b0;
`else
            t       <= 8'h01;
`endif
         end
      end else begin
         sc         <= sc_n;
         t          <= 8'd1 << sc_n;
         q          <= q_n;
         instr_done <= last_n;
         halt_l     <= halt_l | halt_req;
         if (sc == 3'd2 && opcode_in == 2'b11) illegal_op <= 1'b1;
      end
   end
endmodule

// File: tb/tb_mano_timing_sequencer.sv
// tb_mano_timing_sequencer: directed + random checks of the timing sequencer against an instruction-level model
module tb_mano_timing_sequencer;
   localparam int E1 = 3, E2 = 5, E3 = 7, CW = 8;
   logic          clk = 0, rst_n = 0, run = 0, halt_req = 0;
   logic [1:0]    opcode_in = 0;
   logic [7:0]    t;
   logic [2:0]    q;
   logic          instr_done, illegal_op, running;
   logic [CW-1:0] icount;
   int            checks = 0, failures = 0;
   int            end_tab [4] = '{E1, E2, E3, 3};
   logic [2:0]    cls_tab [4] = '{3'b001, 3'b010, 3'b100, 3'b000};
   int            m_mode, m_k, m_end;
   logic [2:0]    m_q;
   logic          m_ill, m_hl;
   logic [CW-1:0] m_cnt;

   always #5 clk = ~clk;

   mano_timing_sequencer #(.END_Q1(E1), .END_Q2(E2), .END_Q3(E3), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .halt_req(halt_req), .opcode_in(opcode_in),
      .t(t), .q(q), .instr_done(instr_done), .illegal_op(illegal_op),
      .icount(icount), .running(running)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // mode: 0 idle, 1 run, 2 halted; m_k is the timing step within the current instruction
   task automatic model(input logic rn, input logic r, input logic h, input logic [1:0] o);
      if (!rn) begin
         m_mode = 0; m_k = 0; m_q = 0; m_ill = 0; m_hl = 0; m_cnt = 0;
      end else if (m_mode != 1) begin
         if (r && !h) begin m_mode = 1; m_k = 0; end
      end else begin
         m_hl = m_hl | h;
         if (m_k == 2) begin
            m_q = cls_tab[o]; m_end = end_tab[o]; m_ill = m_ill | (o == 2'b11);
         end
         if (m_k > 2 && m_k == m_end) begin
            m_cnt = m_cnt + 1'b1; m_k = 0;
            if (m_hl) begin m_mode = 2; m_hl = 0; end
         end else m_k++;
      end
   endtask

   task automatic cyc(input logic rn, input logic r, input logic h, input logic [1:0] o);
      rst_n = rn; run = r; halt_req = h; opcode_in = o;
      @(posedge clk);
      model(rn, r, h, o);
      #1;
      chk("t", t, m_mode == 1 ? 32'(1) << m_k : 0);
      chk("q", q, m_q);
      chk("instr_done", instr_done, m_mode == 1 && m_k > 2 && m_k == m_end);
      chk("illegal_op", illegal_op, m_ill);
      chk("icount", icount, m_cnt);
      chk("running", running, m_mode == 1);
      chk("t_onehot", running ? $onehot(t) : t == 8'h00, 1);
   endtask

   // runs one full instruction (from T0) with opcode o, halt pulse at step halt_at
   task automatic instr(input logic [1:0] o, input int halt_at);
      logic [CW-1:0] was = m_cnt;
      for (int i = 0; i < 12 && m_cnt == was; i++) cyc(1, 0, m_mode == 1 && m_k == halt_at, o);
   endtask

   initial begin
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      chk("reset_t", t, 0);
      cyc(1, 1, 0, 0);
      chk("start_t0", t, 8'h01);
      instr(2'b00, -1);
      chk("first_icount", icount, 1);
      chk("first_next_t0", t, 8'h01);
      chk("first_q", q, 3'b001);
      instr(2'b01, -1);
      instr(2'b10, -1);
      chk("b2b_icount", icount, 3);
      instr(2'b11, -1);
      chk("illegal_set", illegal_op, 1);
      chk("illegal_q", q, 3'b000);
      instr(2'b00, -1);
      chk("illegal_sticky", illegal_op, 1);
      instr(2'b10, 1);
      chk("halt_running", running, 0);
      chk("halt_t", t, 0);
      cyc(0 == 1 ? 0 : 1, 0, 0, 0);
      chk("halted_stays", running, 0);
      cyc(1, 1, 0, 0);
      chk("resume_t0", t, 8'h01);
      for (int i = 0; i < 10 && m_k != 4; i++) cyc(1, 0, 0, 2'b01);
      cyc(0, 0, 0, 0);
      chk("midreset_icount", icount, 0);
      chk("midreset_t", t, 0);
      cyc(1, 1, 1, 0);
      cyc(1, 1, 1, 0);
      chk("run_and_halt_idle", running, 0);
      for (int i = 0; i < 500; i++)
         cyc($urandom_range(0, 99) != 0, $urandom_range(0, 99) < 20,
             $urandom_range(0, 99) < 5, 2'($urandom_range(0, 3)));
      cyc(0, 0, 0, 0);
      cyc(1, 1, 0, 0);
      for (int i = 0; i < 260; i++) instr(2'($urandom_range(0, 3)), -1);
      chk("icount_wrap", icount, 8'd4);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
